// File: rtl/alu_result_serializer.sv
// alu_result_serializer: captures an ALU result with its op code and streams it as a header beat plus N/W chunks
module alu_result_serializer #(
    parameter int N = 128,
    parameter int W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               result,
    input  logic [3:0]                 ALUControl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic                       out_last,
    output logic [$clog2(N/W+1)-1:0]   out_idx,
    output logic                       flag_z,
    output logic                       flag_n
);
    localparam int C  = N / W;
    localparam int IW = $clog2(C + 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t          state, state_n;
    logic [N-1:0]    sh;
    logic [3:0]      op;

    assign in_ready  = state == IDLE;
    assign out_valid = state != IDLE;
    assign out_last  = state == DATA && out_idx == IW'(C);

    // state register; reset abandons any transfer in flight
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    // next state: capture, header handshake, then chunks until the last one is taken
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? HEADER : IDLE;
            HEADER:  state_n = out_ready ? DATA : HEADER;
            DATA:    state_n = out_ready && out_last ? IDLE : DATA;
            default: state_n = IDLE;
        endcase
    end

    // capture result/op/flags in IDLE, then advance beat index and shift chunks out on each accept
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sh      <= '0;
            op      <= '0;
            out_idx <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sh      <= result;
            op      <= ALUControl;
            out_idx <= '0;
            flag_z  <= result == '0;
            flag_n  <= result[N-1];
        end else if (state == HEADER && out_ready) begin
            out_idx <= out_idx + IW'(1);
        end else if (state == DATA && out_ready && !out_last) begin
            sh      <= sh >> W;
            out_idx <= out_idx + IW'(1);
        end

    // output word: header holds {op, 2'b00, n, z} zero-extended, data holds the low chunk of sh
    always_comb begin
        out_data = '0;
        if (state == HEADER) out_data[7:0] = {op, 2'b00, flag_n, flag_z};
        else if (state == DATA) out_data = sh[W-1:0];
    end
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: scoreboard bench for the serializer at N=128, W=8
module tb_alu_result_serializer;
    localparam int N = 128;
    localparam int W = 8;
    localparam int C = N / W;

    typedef struct {
        logic [7:0] d;
        logic [4:0] i;
        logic       l;
    } beat_t;

    logic         clk = 0;
    logic         rst = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [N-1:0] result = '0;
    logic [3:0]   ALUControl = '0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [4:0]   out_idx;
    logic         flag_z;
    logic         flag_n;

    int checks = 0;
    int failures = 0;
    beat_t sb[$];

    alu_result_serializer #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_idx(out_idx), .flag_z(flag_z), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // expected beats: header then chunks LSB first
    task automatic push(input logic [N-1:0] r, input logic [3:0] op);
        beat_t b;
        b.d = {op, 2'b00, r[N-1], (r == '0)};
        b.i = 5'd0;
        b.l = 1'b0;
        sb.push_back(b);
        for (int k = 1; k <= C; k++) begin
            b.d = r[8*(k-1) +: 8];
            b.i = 5'(k);
            b.l = (k == C);
            sb.push_back(b);
        end
    endtask

    task automatic send(input logic [N-1:0] r, input logic [3:0] op, input bit hold);
        int n = 0;
        in_valid = 1;
        result = r;
        ALUControl = op;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_wait: in_ready=%b expected 1 within 100 cycles", in_ready);
        end
        @(posedge clk); #1;
        if (!hold) in_valid = 0;
    endtask

    task automatic drain(input int max_beats, input bit rnd, output int beats);
        int cyc = 0;
        bit stall = 0;
        logic [7:0] pd;
        logic [4:0] pi;
        logic pl;
        beat_t e;
        beats = 0;
        while (sb.size() > 0 && beats < max_beats && cyc < 1000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                checks++;
                if (!out_valid || out_data !== pd || out_idx !== pi || out_last !== pl) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=%b",
                             out_valid, out_data, out_idx, out_last, pd, pi, pl);
                end
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            pi = out_idx;
            pl = out_last;
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                checks++;
                if (out_data !== e.d || out_idx !== e.i || out_last !== e.l) begin
                    failures++;
                    $display("FAIL beat: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                             out_data, out_idx, out_last, e.d, e.i, e.l);
                end
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 0;
        if (sb.size() > 0 && beats < max_beats) begin
            checks++; failures++;
            $display("FAIL drain_timeout: beats=%0d expected %0d", beats, max_beats);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_last, out_idx, flag_z, flag_n} !== {1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_vals: got rdy=%b v=%b d=%h l=%b i=%0d z=%b n=%b expected 1 0 00 0 0 0 0",
                     in_ready, out_valid, out_data, out_last, out_idx, flag_z, flag_n);
        end
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b v=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero;
        int b;
        push('0, 4'b0010);
        send('0, 4'b0010, 0);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== 8'h21 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_header: got v=%b i=%0d d=%h rdy=%b expected 1 0 21 0", out_valid, out_idx, out_data, in_ready);
        end
        checks++;
        if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
            failures++;
            $display("FAIL zero_flags: got z=%b n=%b expected z=1 n=0", flag_z, flag_n);
        end
        drain(17, 0, b);
        checks++;
        if (b !== 17 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_end: got beats=%0d rdy=%b v=%b expected 17 1 0", b, in_ready, out_valid);
        end
    endtask

    task automatic test_msb_lsb;
        int b;
        logic [N-1:0] r;
        r = '0;
        r[N-1] = 1'b1;
        r[0] = 1'b1;
        push(r, 4'b0111);
        send(r, 4'b0111, 0);
        checks++;
        if (out_data !== 8'h72 || flag_n !== 1'b1 || flag_z !== 1'b0) begin
            failures++;
            $display("FAIL msb_header: got d=%h n=%b z=%b expected 72 1 0", out_data, flag_n, flag_z);
        end
        drain(17, 0, b);
        checks++;
        if (b !== 17 || flag_n !== 1'b1) begin
            failures++;
            $display("FAIL msb_end: got beats=%0d n=%b expected 17 1", b, flag_n);
        end
    endtask

    task automatic test_backpressure;
        int b;
        logic [N-1:0] r;
        for (int k = 0; k < C; k++) r[8*k +: 8] = 8'(k);
        push(r, 4'hA);
        send(r, 4'hA, 0);
        drain(100, 1, b);
        out_ready = 1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (b !== 17 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_count: got beats=%0d v=%b expected 17 0", b, out_valid);
        end
        out_ready = 0;
    endtask

    task automatic test_back_to_back;
        int b;
        int n;
        logic [N-1:0] ra;
        ra = {4{32'hDEAD_BEEF}};
        push(ra, 4'h5);
        push('0, 4'h3);
        send(ra, 4'h5, 1);
        result = '0;
        ALUControl = 4'h3;
        fork
            drain(34, 0, b);
            begin
                n = 0;
                while (!in_ready && n < 40) begin
                    @(posedge clk); #1;
                    n++;
                end
                @(posedge clk); #1;
                in_valid = 0;
                checks++;
                if (n !== 17) begin
                    failures++;
                    $display("FAIL b2b_ready_gap: got %0d cycles expected 17", n);
                end
                checks++;
                if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_flags: got z=%b n=%b expected z=1 n=0", flag_z, flag_n);
                end
            end
        join
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (b !== 34 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end: got beats=%0d v=%b rdy=%b expected 34 0 1", b, out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        int b;
        logic [N-1:0] r;
        r = {32'h8123_4567, 32'h89AB_CDEF, 32'h0246_8ACE, 32'h1357_9BDF};
        push(r, 4'hC);
        send(r, 4'hC, 0);
        drain(5, 0, b);
        sb.delete();
        #2 rst = 1;
        #1;
        checks++;
        if ({out_valid, out_data, out_idx, out_last, flag_z, flag_n, in_ready} !== {1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset: got v=%b d=%h i=%0d l=%b z=%b n=%b rdy=%b expected 0 00 0 0 0 0 1",
                     out_valid, out_data, out_idx, out_last, flag_z, flag_n, in_ready);
        end
        @(posedge clk); #1 rst = 0;
        r = 128'h7;
        push(r, 4'h1);
        send(r, 4'h1, 0);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== 8'h10) begin
            failures++;
            $display("FAIL mid_restart: got v=%b i=%0d d=%h expected 1 0 10", out_valid, out_idx, out_data);
        end
        drain(17, 0, b);
        checks++;
        if (b !== 17) begin
            failures++;
            $display("FAIL mid_restart_count: got %0d expected 17", b);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_msb_lsb();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
